// File: rtl/can_rx_buffer.sv
// CAN receive buffer: ID/mask acceptance filter feeding an N-deep in-order frame FIFO,
// with sticky overrun flag and a saturating count of filtered-out frames.
module can_rx_buffer #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [10:0]                rx_id,
    input  logic [3:0]                 rx_dlc,
    input  logic [7:0][7:0]            rx_data,
    input  logic [10:0]                acc_code,
    input  logic [10:0]                acc_mask,
    input  logic                       rd_en,
    input  logic                       clr_overrun,
    output logic                       out_valid,
    output logic [10:0]                out_id,
    output logic [3:0]                 out_dlc,
    output logic [7:0][7:0]            out_data,
    output logic [$clog2(N+1)-1:0]     count,
    output logic                       overrun,
    output logic [CW-1:0]              rej_count
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [10:0]      id_mem_r   [N];
    logic [3:0]       dlc_mem_r  [N];
    logic [7:0][7:0]  data_mem_r [N];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overrun_r;
    logic [CW-1:0]    rej_count_r;

    logic             accept_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_s;
    logic             rd_s;
    logic             ovr_set_s;
    logic             rej_s;
    logic [3:0]       len_s;
    logic [7:0][7:0]  wdata_s;

    // Pointers run 0..N-1 even when N is not a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(N - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Filter decision and FIFO push/pop qualification.
    always_comb begin
        accept_s  = rx_valid && (((rx_id ^ acc_code) & acc_mask) == 11'd0);
        full_s    = (count_r == CNT_W'(N));
        empty_s   = (count_r == {CNT_W{1'b0}});
        wr_s      = accept_s && (!full_s || rd_en);
        rd_s      = rd_en && !empty_s;
        ovr_set_s = accept_s && full_s && !rd_en;
        rej_s     = rx_valid && !accept_s;
    end

    // Bytes beyond the DLC (capped at 8) are stored as zero.
    always_comb begin
        len_s = (rx_dlc > 4'd8) ? 4'd8 : rx_dlc;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < len_s) begin
                wdata_s[j] = rx_data[j];
            end else begin
                wdata_s[j] = 8'h00;
            end
        end
    end

    // Frame storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!rst && wr_s) begin
            id_mem_r[wr_ptr_r]   <= rx_id;
            dlc_mem_r[wr_ptr_r]  <= rx_dlc;
            data_mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // Pointer, occupancy, overrun and reject-counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overrun_r   <= 1'b0;
            rej_count_r <= {CW{1'b0}};
        end else begin
            if (wr_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (rd_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun) begin
                overrun_r <= 1'b0;
            end
            if (rej_s && (rej_count_r != {CW{1'b1}})) begin
                rej_count_r <= rej_count_r + CW'(1);
            end
        end
    end

    // Head-of-queue view, forced to zero while empty.
    always_comb begin
        out_valid = !empty_s;
        out_id    = 11'd0;
        out_dlc   = 4'd0;
        out_data  = {8{8'h00}};
        if (!empty_s) begin
            out_id   = id_mem_r[rd_ptr_r];
            out_dlc  = dlc_mem_r[rd_ptr_r];
            out_data = data_mem_r[rd_ptr_r];
        end else begin
            out_id   = 11'd0;
            out_dlc  = 4'd0;
            out_data = {8{8'h00}};
        end
    end

    assign count     = count_r;
    assign overrun   = overrun_r;
    assign rej_count = rej_count_r;

endmodule

// File: tb/tb_can_rx_buffer.sv
// Self-checking bench for can_rx_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_can_rx_buffer;

    localparam int N  = 4;
    localparam int CW = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   rx_valid;
    logic [10:0]            rx_id;
    logic [3:0]             rx_dlc;
    logic [7:0][7:0]        rx_data;
    logic [10:0]            acc_code;
    logic [10:0]            acc_mask;
    logic                   rd_en;
    logic                   clr_overrun;
    logic                   out_valid;
    logic [10:0]            out_id;
    logic [3:0]             out_dlc;
    logic [7:0][7:0]        out_data;
    logic [$clog2(N+1)-1:0] count;
    logic                   overrun;
    logic [CW-1:0]          rej_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0]     id;
        logic [3:0]      dlc;
        logic [7:0][7:0] data;
    } frame_t;

    frame_t q[$];
    bit     m_ovr;
    int     m_rej;

    logic            e_valid;
    logic [10:0]     e_id;
    logic [3:0]      e_dlc;
    logic [7:0][7:0] e_data;

    can_rx_buffer #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_id(rx_id), .rx_dlc(rx_dlc),
        .rx_data(rx_data), .acc_code(acc_code), .acc_mask(acc_mask), .rd_en(rd_en),
        .clr_overrun(clr_overrun), .out_valid(out_valid), .out_id(out_id),
        .out_dlc(out_dlc), .out_data(out_data), .count(count), .overrun(overrun),
        .rej_count(rej_count)
    );

    always #5 clk = ~clk;

    // Reference: apply one clock edge's worth of behaviour to the queue model.
    task automatic model_edge();
        bit     acc, pop, push, was_full;
        frame_t f;
        int     len;
        if (rst) begin
            q.delete();
            m_ovr = 1'b0;
            m_rej = 0;
            return;
        end
        acc      = rx_valid && ((rx_id & acc_mask) == (acc_code & acc_mask));
        was_full = (q.size() == N);
        pop      = rd_en && (q.size() > 0);
        push     = acc && (!was_full || rd_en);
        if (pop) void'(q.pop_front());
        if (push) begin
            len    = (rx_dlc > 8) ? 8 : int'(rx_dlc);
            f.id   = rx_id;
            f.dlc  = rx_dlc;
            f.data = '0;
            for (int j = 0; j < len; j++) f.data[j] = rx_data[j];
            q.push_back(f);
        end
        if (acc && was_full && !rd_en) m_ovr = 1'b1;
        else if (clr_overrun) m_ovr = 1'b0;
        if (rx_valid && !acc) m_rej = (m_rej >= 255) ? 255 : m_rej + 1;
    endtask

    task automatic model_expect();
        e_valid = (q.size() > 0);
        e_id    = e_valid ? q[0].id : 11'd0;
        e_dlc   = e_valid ? q[0].dlc : 4'd0;
        e_data  = e_valid ? q[0].data : '0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        rst = 1'b0; rx_valid = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        model_expect();
    endtask

    task automatic send(input logic [10:0] id, input logic [3:0] dlc);
        rx_valid = 1'b1; rx_id = id; rx_dlc = dlc;
        for (int j = 0; j < 8; j++) rx_data[j] = 8'($urandom);
        step();
    endtask

    task automatic pop_check(input logic [10:0] want, input string tag);
        checks++;
        if (out_id !== want) begin
            errors++;
            $display("FAIL %s head id got %h want %h", tag, out_id, want);
        end
        rd_en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; step();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overrun !== 1'b0 || rej_count !== 8'd0) begin
            errors++;
            $display("FAIL reset cnt=%0d v=%b ovr=%b rej=%0d want 0", count, out_valid, overrun, rej_count);
        end
        checks++;
        if (out_id !== 11'd0 || out_dlc !== 4'd0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_out id=%h dlc=%h data=%h want 0", out_id, out_dlc, out_data);
        end
    endtask

    task automatic test_basic();
        logic [7:0][7:0] want;
        acc_mask = 11'h000;
        rx_valid = 1'b1; rx_id = 11'h123; rx_dlc = 4'd2;
        for (int j = 0; j < 8; j++) rx_data[j] = 8'h11;
        rx_data[0] = 8'hAA; rx_data[1] = 8'hBB;
        step();
        want = '0; want[0] = 8'hAA; want[1] = 8'hBB;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 11'h123 || out_dlc !== 4'd2 || count !== 3'd1) begin
            errors++;
            $display("FAIL basic v=%b id=%h dlc=%0d cnt=%0d want 1/123/2/1", out_valid, out_id, out_dlc, count);
        end
        checks++;
        if (out_data !== want) begin
            errors++;
            $display("FAIL basic_data got %h want %h", out_data, want);
        end
        rd_en = 1'b1; step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_id !== 11'd0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL basic_pop v=%b cnt=%0d id=%h data=%h want 0", out_valid, count, out_id, out_data);
        end
    endtask

    task automatic test_filter();
        acc_code = 11'h100; acc_mask = 11'h700;
        send(11'h1FF, 4'd8); send(11'h200, 4'd8); send(11'h10A, 4'd8);
        checks++;
        if (rej_count !== 8'd1 || count !== 3'd2) begin
            errors++;
            $display("FAIL filter rej=%0d cnt=%0d want 1/2", rej_count, count);
        end
        pop_check(11'h1FF, "filter0");
        pop_check(11'h10A, "filter1");
        acc_mask = 11'h000;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) send(11'(i), 4'd1);
        checks++;
        if (count !== 3'd4 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set cnt=%0d ovr=%b want 4/1", count, overrun);
        end
        for (int i = 1; i <= 4; i++) pop_check(11'(i), "ovr_pop");
        clr_overrun = 1'b1; step();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr got %b want 0", overrun);
        end
        for (int i = 1; i <= 4; i++) send(11'(i), 4'd1);
        clr_overrun = 1'b1; send(11'd5, 4'd1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_prio got %b want 1", overrun);
        end
        for (int i = 1; i <= 4; i++) pop_check(11'(i), "ovr_pop2");
        clr_overrun = 1'b1; step();
    endtask

    task automatic test_full_simul();
        for (int i = 1; i <= 4; i++) send(11'(i), 4'd3);
        rd_en = 1'b1; send(11'd9, 4'd3);
        checks++;
        if (count !== 3'd4 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_simul cnt=%0d ovr=%b want 4/0", count, overrun);
        end
        pop_check(11'd2, "full_simul"); pop_check(11'd3, "full_simul");
        pop_check(11'd4, "full_simul"); pop_check(11'd9, "full_simul");
    endtask

    task automatic test_dlc_empty_rej();
        rx_valid = 1'b1; rx_id = 11'h055; rx_dlc = 4'd12;
        for (int j = 0; j < 8; j++) rx_data[j] = 8'hFF;
        step();
        checks++;
        if (out_dlc !== 4'd12 || out_data !== {8{8'hFF}}) begin
            errors++;
            $display("FAIL dlc_clamp dlc=%0d data=%h want 12/all FF", out_dlc, out_data);
        end
        rd_en = 1'b1; step();
        rd_en = 1'b1; step();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_read cnt=%0d v=%b want 0/0", count, out_valid);
        end
        rd_en = 1'b1; send(11'h321, 4'd4);
        checks++;
        if (count !== 3'd1 || out_id !== 11'h321) begin
            errors++;
            $display("FAIL empty_rw cnt=%0d id=%h want 1/321", count, out_id);
        end
        rd_en = 1'b1; step();
        acc_code = 11'h7FF; acc_mask = 11'h7FF;
        for (int i = 0; i < 260; i++) send(11'(i % 256), 4'd0);
        checks++;
        if (rej_count !== 8'd255) begin
            errors++;
            $display("FAIL rej_sat got %0d want 255", rej_count);
        end
        acc_mask = 11'h000;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) send(11'(i + 16), 4'd2);
        rd_en = 1'b1; step();
        checks++;
        if (count !== 3'd3 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre cnt=%0d ovr=%b want 3/1", count, overrun);
        end
        rst = 1'b1; send(11'h0AA, 4'd2);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overrun !== 1'b0 || rej_count !== 8'd0) begin
            errors++;
            $display("FAIL rstmid cnt=%0d v=%b ovr=%b rej=%0d want 0", count, out_valid, overrun, rej_count);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 600; c++) begin
            rx_valid    = ($urandom_range(0, 9) < 6);
            rx_id       = 11'($urandom);
            rx_dlc      = 4'($urandom);
            for (int j = 0; j < 8; j++) rx_data[j] = 8'($urandom);
            rd_en       = ($urandom_range(0, 9) < 4);
            clr_overrun = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            if ((c % 50) == 0) begin
                acc_code = 11'($urandom);
                acc_mask = 11'($urandom) & 11'($urandom);
            end
            step();
            checks++;
            if (out_valid !== e_valid || out_id !== e_id || out_dlc !== e_dlc || out_data !== e_data ||
                count !== 3'(q.size()) || overrun !== m_ovr || rej_count !== 8'(m_rej)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random c=%0d v=%b id=%h dlc=%h cnt=%0d ovr=%b rej=%0d want v=%b id=%h dlc=%h cnt=%0d ovr=%b rej=%0d",
                             c, out_valid, out_id, out_dlc, count, overrun, rej_count,
                             e_valid, e_id, e_dlc, q.size(), m_ovr, m_rej);
            end
        end
    endtask

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_id = 11'd0; rx_dlc = 4'd0; rx_data = '0;
        acc_code = 11'd0; acc_mask = 11'd0; rd_en = 1'b0; clr_overrun = 1'b0;
        q.delete(); m_ovr = 1'b0; m_rej = 0;
        #2;
        test_reset();
        test_basic();
        test_filter();
        test_overrun();
        test_full_simul();
        test_dlc_empty_rej();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_rx_buffer.md
Name: can_rx_buffer

Overview:
Receive-side counterpart of the transmit priority buffer.
- Takes completed frames from the CAN receiver core and applies an ID/mask acceptance filter.
- Stores accepted frames in an N-deep FIFO in arrival order.
- Presents the oldest frame to the host through a valid/read handshake.
- Reports overrun (frame lost when full) and keeps a saturating count of filtered-out frames.

Parameters:
N, 4, FIFO depth in frames; any integer >= 2; pointers wrap at N-1.
CW, 8, width of the rejected-frame counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
rx_valid  input  1  one-cycle pulse: complete frame available on rx_id/rx_dlc/rx_data
rx_id  input  11  received CAN ID
rx_dlc  input  4  received Data Length Code (0..15)
rx_data  input  8 x [8]  received data bytes, index 0 first
acc_code  input  11  acceptance code
acc_mask  input  11  acceptance mask; 1 = bit must match acc_code, 0 = don't care
rd_en  input  1  host pops head frame this cycle
clr_overrun  input  1  clears overrun flag
out_valid  output  1  FIFO non-empty; out_* hold head frame
out_id  output  11  head frame ID
out_dlc  output  4  head frame DLC as received
out_data  output  8 x [8]  head frame data
count  output  clog2(N+1)  frames currently stored
overrun  output  1  sticky: accepted frame dropped because FIFO full
rej_count  output  CW  saturating count of frames rejected by filter

Behaviour:
- Reset (rst high at edge): rd_ptr=0, wr_ptr=0, count=0, overrun=0, rej_count=0. Storage contents are don't-care. Reset overrides every other input in that cycle.
- Acceptance: accept = rx_valid && (((rx_id ^ acc_code) & acc_mask) == 0). acc_mask=0 accepts all frames. Filter is evaluated combinationally in the rx_valid cycle using the current acc_code/acc_mask.
- Rejection: rx_valid && !accept -> rej_count += 1, saturating at 2^CW-1; nothing stored.
- Write condition: accept && (count<N || rd_en). Stores id, dlc, data at wr_ptr; wr_ptr advances, wrapping N-1 -> 0.
- Data stored: byte j is stored as rx_data[j] if j < min(rx_dlc,8), else 0. DLC 9..15 is stored unchanged and treated as 8 bytes.
- Read: rd_en && count>0 -> rd_ptr advances with wrap. rd_en while empty is ignored with no state change.
- count update: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Full and simultaneous: count==N with accept && rd_en -> pop and push in the same edge; count stays N, no overrun.
- Overrun: accept && count==N && !rd_en -> frame dropped, overrun<=1. Set has priority over clr_overrun in the same cycle. Otherwise clr_overrun -> overrun<=0.
- Outputs: out_valid = (count!=0). out_id/out_dlc/out_data are combinational from the entry at rd_ptr when out_valid, else all zero.
- Latency: frame accepted at edge k is visible on out_* from edge k onward (next cycle) if the FIFO was empty. Pop at edge k shows the next entry from edge k.
- Empty with simultaneous accept and rd_en: the read is ignored and the write proceeds, so count becomes 1.
- No FSM. Behaviour is pointer/count sequential. Internal width of count and pointers derives from clog2, computed locally.

Test Plan:
1. Reset, then acc_mask=0: pulse rx_valid with id=0x123, dlc=2, data={0xAA,0xBB,0x11,...} -> next cycle out_valid=1, out_id=0x123, out_dlc=2, out_data={0xAA,0xBB,0,0,0,0,0,0}, count=1. Then rd_en=1 -> out_valid=0, count=0, all out_* zero.
2. Filter: acc_code=0x100, acc_mask=0x700; send ids 0x1FF, 0x200, 0x10A -> 0x1FF and 0x10A stored in order, rej_count=1, count=2.
3. Overrun: N=4, write 5 accepted frames ids 1..5 with no reads -> count=4, overrun=1, pops yield ids 1,2,3,4. Then clr_overrun -> overrun=0. Repeat with set and clear in the same cycle -> overrun stays 1.
4. Full with simultaneous traffic: fill ids 1..4, then rx_valid id=9 and rd_en in the same cycle -> count=4, overrun=0, pop sequence 2,3,4,9 (pointer wrap exercised).
5. DLC clamp and empty read: rx_dlc=12 with all data bytes 0xFF -> out_dlc=12, all 8 bytes 0xFF. rd_en on an empty FIFO -> count stays 0. Send 260 rejected frames with CW=8 -> rej_count=255.
6. Reset mid-operation: 3 frames stored, overrun=1, then rst=1 for one cycle together with rx_valid -> next cycle count=0, out_valid=0, overrun=0, rej_count=0, nothing written.
